// File: rtl/mem_fifo_ctrl_32x64_if.sv
// Stream and SRAM-port bundle for mem_fifo_ctrl_32x64.
// slave  : the FIFO controller side (drives in_ready, out_*, mem_W0_*, mem_R0_addr/en).
// master : the surrounding producer/consumer/SRAM side.
interface mem_fifo_ctrl_32x64_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5,
  parameter int MASK_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic              mem_W0_en;
  logic [WIDTH-1:0]  mem_W0_data;
  logic [MASK_W-1:0] mem_W0_mask;
  logic [ADDR_W-1:0] mem_R0_addr;
  logic              mem_R0_en;
  logic [WIDTH-1:0]  mem_R0_data;

  modport slave (
    input  in_valid, in_data, out_ready, mem_R0_data,
    output in_ready, out_valid, out_data,
    output mem_W0_addr, mem_W0_en, mem_W0_data, mem_W0_mask,
    output mem_R0_addr, mem_R0_en
  );

  modport master (
    output in_valid, in_data, out_ready, mem_R0_data,
    input  in_ready, out_valid, out_data,
    input  mem_W0_addr, mem_W0_en, mem_W0_data, mem_W0_mask,
    input  mem_R0_addr, mem_R0_en
  );
endinterface

// File: rtl/mem_fifo_ctrl_32x64.sv
// Synchronous FIFO controller in front of a 32x64 1R1W masked SRAM.
// Reads are issued ahead into a 2-entry skid buffer so the one-cycle SRAM
// read latency is hidden and one push plus one pop can happen every cycle.
// Optional feature macro: MEM_FIFO_CTRL_LEVEL_EN adds a registered `level`
// output (total stored entries, SRAM + in flight + buffer).
module mem_fifo_ctrl_32x64 #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5,
  parameter int MASK_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  mem_fifo_ctrl_32x64_if.slave bus
`ifdef MEM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_W+1:0]    level
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  // Pointers carry one extra MSB so full (count == DEPTH) differs from empty.
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       buf_count_q, buf_count_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;   // head of the skid buffer
  logic [WIDTH-1:0] buf1_q, buf1_d;   // second entry
  logic             in_ready_q, in_ready_d;

  logic [ADDR_W:0]  mem_count_s;
  logic             push_s;
  logic             pop_s;
  logic             rd_s;
  logic [2:0]       occ_s;
  logic [1:0]       cnt_after_pop_s;

  // in_ready depends only on SRAM occupancy; the buffer is refilled by reads.
  assign mem_count_s     = wr_ptr_q - rd_ptr_q;
  assign bus.in_ready    = in_ready_q && (mem_count_s != FULL_CNT);
  assign bus.out_valid   = (buf_count_q != 2'd0);
  assign bus.out_data    = buf0_q;
  assign push_s          = bus.in_valid && bus.in_ready && !flush;
  assign pop_s           = bus.out_valid && bus.out_ready && !flush;
  // Buffer slots that stay claimed after this cycle's pop, counting the read
  // already in flight; a new read is issued only if one slot remains free.
  assign occ_s           = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign rd_s            = (mem_count_s != {(ADDR_W+1){1'b0}}) && (occ_s < 3'd2) && !flush;
  assign cnt_after_pop_s = buf_count_q - {1'b0, pop_s};

  assign bus.mem_W0_en   = push_s;
  assign bus.mem_W0_addr = wr_ptr_q[ADDR_W-1:0];
  assign bus.mem_W0_data = bus.in_data;
  assign bus.mem_W0_mask = {MASK_W{1'b1}};
  assign bus.mem_R0_en   = rd_s;
  assign bus.mem_R0_addr = rd_ptr_q[ADDR_W-1:0];

  // Next-state for pointers, read tracking and the in-order skid buffer.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = 1'b0;
    buf_count_d = buf_count_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    in_ready_d  = 1'b1;
    if (flush) begin
      // Dropping inflight and buf_count discards any read data still returning.
      wr_ptr_d    = {(ADDR_W+1){1'b0}};
      rd_ptr_d    = {(ADDR_W+1){1'b0}};
      inflight_d  = 1'b0;
      buf_count_d = 2'd0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_s) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        inflight_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
        inflight_d = 1'b0;
      end
      if (pop_s) begin
        buf0_d = buf1_q;
      end else begin
        buf0_d = buf0_q;
      end
      // Returning SRAM data lands at the tail left after the pop.
      if (inflight_q) begin
        case (cnt_after_pop_s)
          2'd0:    buf0_d = bus.mem_R0_data;
          default: buf1_d = bus.mem_R0_data;
        endcase
      end else begin
        buf1_d = buf1_q;
      end
      buf_count_d = cnt_after_pop_s + {1'b0, inflight_q};
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= {(ADDR_W+1){1'b0}};
      rd_ptr_q    <= {(ADDR_W+1){1'b0}};
      inflight_q  <= 1'b0;
      buf_count_q <= 2'd0;
      buf0_q      <= {WIDTH{1'b0}};
      buf1_q      <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      buf_count_q <= buf_count_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef MEM_FIFO_CTRL_LEVEL_EN
  logic [ADDR_W+1:0] level_q, level_d;

  // Total occupancy only moves on push or pop; reads just move entries around.
  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = {(ADDR_W+2){1'b0}};
    end else begin
      level_d = level_q + {{(ADDR_W+1){1'b0}}, push_s} - {{(ADDR_W+1){1'b0}}, pop_s};
    end
  end

  // Occupancy register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= {(ADDR_W+2){1'b0}};
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl_32x64.sv
// Directed self-checking bench for mem_fifo_ctrl_32x64 with a behavioural
// 32x64 masked SRAM (one-cycle read latency) attached to the memory ports.
module tb_mem_fifo_ctrl_32x64;

  logic clock;
  logic reset_n;
  logic flush;
  int   total;
  int   bad;

  mem_fifo_ctrl_32x64_if bus ();
`ifdef MEM_FIFO_CTRL_LEVEL_EN
  logic [6:0] level;
`endif

  mem_fifo_ctrl_32x64 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural SRAM model.
  logic [63:0] sram [32];
  always @(posedge clock) begin
    if (bus.mem_W0_en) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.mem_W0_mask[b]) sram[bus.mem_W0_addr][b*8 +: 8] <= bus.mem_W0_data[b*8 +: 8];
      end
    end
    if (bus.mem_R0_en) bus.mem_R0_data <= sram[bus.mem_R0_addr];
  end

  function automatic logic [63:0] val(input int tag, input int k);
    return {32'(tag), 32'(k)};
  endfunction

  task automatic test_reset();
    @(negedge clock); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 64'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.mem_W0_en !== 1'b0 || bus.mem_R0_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b%b exp=00", bus.mem_W0_en, bus.mem_R0_en); end
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    total++; if (level !== 7'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
`endif
    reset_n = 1'b1; #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready got=%b exp=0", bus.in_ready); end
    @(negedge clock); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL first_edge_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_single();
    @(negedge clock); bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0000_00A5; bus.out_ready = 1'b1; #1;
    total++; if (bus.mem_W0_en !== 1'b1 || bus.mem_W0_addr !== 5'd0) begin bad++; $display("FAIL single_wr got=%b/%0d exp=1/0", bus.mem_W0_en, bus.mem_W0_addr); end
    total++; if (bus.mem_W0_mask !== 8'hFF || bus.mem_W0_data !== 64'hA5) begin bad++; $display("FAIL single_wr_mask_data got=%h/%h exp=ff/a5", bus.mem_W0_mask, bus.mem_W0_data); end
    total++; if (bus.mem_R0_en !== 1'b0) begin bad++; $display("FAIL single_no_rd got=%b exp=0", bus.mem_R0_en); end
    @(negedge clock); bus.in_valid = 1'b0; #1;
    total++; if (bus.mem_R0_en !== 1'b1 || bus.mem_R0_addr !== 5'd0) begin bad++; $display("FAIL single_rd got=%b/%0d exp=1/0", bus.mem_R0_en, bus.mem_R0_addr); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_lat1 got=%b exp=0", bus.out_valid); end
    @(negedge clock); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_lat2 got=%b exp=0", bus.out_valid); end
    @(negedge clock); #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hA5) begin bad++; $display("FAIL single_out got=%b/%h exp=1/a5", bus.out_valid, bus.out_data); end
    @(negedge clock); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_fill();
    int acc = 0;
    int idx;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 34; c++) begin
      @(negedge clock); bus.in_valid = 1'b1; bus.in_data = val(1, acc); #1;
      if (bus.in_ready === 1'b1) acc++;
    end
    total++; if (acc !== 34) begin bad++; $display("FAIL fill_accepted got=%0d exp=34", acc); end
    @(negedge clock); bus.in_data = val(1, 99); #1;
    total++; if (bus.in_ready !== 1'b0 || bus.mem_W0_en !== 1'b0) begin bad++; $display("FAIL fill_full got=%b/%b exp=0/0", bus.in_ready, bus.mem_W0_en); end
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== val(1, 0)) begin bad++; $display("FAIL fill_head got=%b/%h exp=1/%h", bus.out_valid, bus.out_data, val(1, 0)); end
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    total++; if (level !== 7'd34) begin bad++; $display("FAIL fill_level got=%0d exp=34", level); end
`endif
    bus.out_ready = 1'b1; #1;
    total++; if (bus.in_ready !== 1'b0 || bus.mem_W0_en !== 1'b0) begin bad++; $display("FAIL full_push_pop got=%b/%b exp=0/0", bus.in_ready, bus.mem_W0_en); end
    @(negedge clock); bus.in_valid = 1'b0; #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL after_pop_in_ready got=%b exp=1", bus.in_ready); end
    idx = 1;
    for (int c = 0; c < 200 && idx < 34; c++) begin
      if (c != 0) begin @(negedge clock); #1; end
      if (bus.out_valid === 1'b1) begin
        total++; if (bus.out_data !== val(1, idx)) begin bad++; $display("FAIL fill_drain[%0d] got=%h exp=%h", idx, bus.out_data, val(1, idx)); end
        idx++;
      end
    end
    total++; if (idx !== 34) begin bad++; $display("FAIL fill_drain_timeout got=%0d exp=34", idx); end
    @(negedge clock); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 103; c++) begin
      @(negedge clock); bus.in_valid = (c < 100); bus.in_data = val(2, c); bus.out_ready = 1'b1; #1;
      if (c < 100) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", c, bus.in_ready); end
      end
      if (c < 3) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_fill[%0d] got=%b exp=0", c, bus.out_valid); end
      end else begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== val(2, c - 3)) begin bad++; $display("FAIL stream_out[%0d] got=%b/%h exp=1/%h", c, bus.out_valid, bus.out_data, val(2, c - 3)); end
      end
    end
    @(negedge clock); bus.in_valid = 1'b0; #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [31:0] a, b;
    int pushed = 0;
    for (int c = 0; c < 6000 && (pushed < 500 || q.size() != 0); c++) begin
      @(negedge clock);
      a = $urandom; b = $urandom;
      bus.in_valid = (pushed < 500); bus.in_data = {a, b}; bus.out_ready = 1'($urandom_range(0, 1)); #1;
      if (bus.mem_W0_en === 1'b1 && bus.in_ready !== 1'b1) begin total++; bad++; $display("FAIL rnd_wr_while_full cycle=%0d", c); end
      if (q.size() < 32) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rnd_in_ready size=%0d got=%b exp=1", q.size(), bus.in_ready); end
      end
      if (q.size() >= 34) begin
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rnd_overflow size=%0d got=%b exp=0", q.size(), bus.in_ready); end
      end
`ifdef MEM_FIFO_CTRL_LEVEL_EN
      total++; if (level !== 7'(q.size())) begin bad++; $display("FAIL rnd_level got=%0d exp=%0d", level, q.size()); end
`endif
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL rnd_spurious got=%h exp=none", bus.out_data); end
        else if (bus.out_data !== q[0]) begin bad++; $display("FAIL rnd_order got=%h exp=%h", bus.out_data, q[0]); void'(q.pop_front()); end
        else void'(q.pop_front());
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin q.push_back(bus.in_data); pushed++; end
    end
    total++; if (pushed !== 500 || q.size() != 0) begin bad++; $display("FAIL rnd_timeout got=%0d/%0d exp=500/0", pushed, q.size()); end
    @(negedge clock); bus.in_valid = 1'b0; bus.out_ready = 1'b0; #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rnd_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    int acc = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); bus.in_valid = 1'b1; bus.in_data = val(3, c); #1;
      if (bus.in_ready === 1'b1) acc++;
    end
    total++; if (acc !== 5) begin bad++; $display("FAIL flush_fill got=%0d exp=5", acc); end
    @(negedge clock); bus.in_valid = 1'b0; bus.out_ready = 1'b1; #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== val(3, 0) || bus.mem_R0_en !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b/%h/%b exp=1/%h/1", bus.out_valid, bus.out_data, bus.mem_R0_en, val(3, 0)); end
    @(negedge clock); bus.out_ready = 1'b0; flush = 1'b1; #1;
    total++; if (bus.mem_R0_en !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL flush_cycle got=%b/%b exp=0/1", bus.mem_R0_en, bus.out_valid); end
    @(negedge clock); flush = 1'b0; #1;
    total++; if (bus.out_valid !== 1'b0 || bus.mem_R0_en !== 1'b0) begin bad++; $display("FAIL flush_cleared got=%b/%b exp=0/0", bus.out_valid, bus.mem_R0_en); end
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    total++; if (level !== 7'd0) begin bad++; $display("FAIL flush_level got=%0d exp=0", level); end
`endif
    bus.in_valid = 1'b1; bus.in_data = 64'h77; bus.out_ready = 1'b1; #1;
    total++; if (bus.mem_W0_en !== 1'b1 || bus.mem_W0_addr !== 5'd0) begin bad++; $display("FAIL flush_wr_addr got=%b/%0d exp=1/0", bus.mem_W0_en, bus.mem_W0_addr); end
    @(negedge clock); bus.in_valid = 1'b0; #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale1 got=%b exp=0", bus.out_valid); end
    @(negedge clock); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale2 got=%b exp=0", bus.out_valid); end
    @(negedge clock); #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h77) begin bad++; $display("FAIL flush_77 got=%b/%h exp=1/77", bus.out_valid, bus.out_data); end
    @(negedge clock); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); bus.in_valid = 1'b1; bus.in_data = val(4, c); #1;
    end
    total++; if (bus.out_valid !== 1'b1 || bus.mem_R0_en !== 1'b1 || bus.mem_W0_en !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b%b%b exp=111", bus.out_valid, bus.mem_R0_en, bus.mem_W0_en); end
    #1 reset_n = 1'b0; #1;
    total++; if (bus.out_valid !== 1'b0 || bus.mem_R0_en !== 1'b0 || bus.mem_W0_en !== 1'b0) begin bad++; $display("FAIL mid_async got=%b%b%b exp=000", bus.out_valid, bus.mem_R0_en, bus.mem_W0_en); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b exp=0", bus.in_ready); end
    @(negedge clock); #1;
    total++; if (bus.in_ready !== 1'b0 || bus.out_data !== 64'h0) begin bad++; $display("FAIL mid_hold got=%b/%h exp=0/0", bus.in_ready, bus.out_data); end
    reset_n = 1'b1; bus.in_valid = 1'b0; #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_release got=%b exp=0", bus.in_ready); end
    @(negedge clock); #1;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_after got=%b/%b exp=1/0", bus.in_ready, bus.out_valid); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 64'h0;
    bus.out_ready = 1'b0;
    bus.mem_R0_data = 64'h0;
    repeat (2) @(negedge clock);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
